bounce_engine: RTL

BOUNCE_ENGINE -- requirements
Module: bounce_engine

---
 rtl/bounce_pkg.sv | 47 ++++
 rtl/rise_detect.sv | 20 ++
 rtl/bounce_engine.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bounce_pkg.sv
// Shared widths, screen defaults, FSM encoding and helpers for the bouncing-object engine.
package bounce_pkg;

  localparam int CORDW      = 11;
  localparam int VELW       = 5;
  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;
  localparam int DEF_OBJ    = 100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC_X,
    S_CALC_Y,
    S_PUBLISH
  } state_e;

  // Observation port: current FSM state, pending command flag and working velocities.
  typedef struct packed {
    state_e            state;
    logic              pending;
    logic [VELW-1:0]   vx;
    logic [VELW-1:0]   vy;
  } dbg_t;

  function automatic logic signed [CORDW-1:0] clamp_pos(
    input logic signed [CORDW-1:0] pos,
    input logic signed [CORDW-1:0] lim
  );
    if (pos < 0)
      return '0;
    else if (pos > lim)
      return lim;
    else
      return pos;
  endfunction

  // The most negative velocity has no positive mirror, so it is pulled in by one.
  function automatic logic signed [VELW-1:0] sat_vel(input logic signed [VELW-1:0] v);
    logic signed [VELW-1:0] vmin;
    vmin = {1'b1, {(VELW-1){1'b0}}};
    if (v == vmin)
      return vmin + VELW'(1);
    else
      return v;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector; the history register resets high so a level held through reset is not an edge.
module rise_detect (
  input  logic clk_pix,
  input  logic btn_rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_prev;

  always_ff @(posedge clk_pix or negedge btn_rst_n) begin
    if (!btn_rst_n)
      sig_prev <= 1'b1;
    else
      sig_prev <= sig;
  end

  assign rise = sig && !sig_prev;

endmodule

// File: rtl/bounce_engine.sv
// Once-per-frame bouncing object position engine with a command port to teleport the object.
// Optional build macro BOUNCE_EVENT_EN adds per-axis bounce pulses and a bounce counter.
module bounce_engine
  import bounce_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int OBJ_W  = DEF_OBJ,
  parameter int OBJ_H  = DEF_OBJ,
  parameter int RST_VX = 1,
  parameter int RST_VY = 1
) (
  input  logic                    clk_pix,
  input  logic                    btn_rst_n,
  input  logic                    vsync,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [CORDW-1:0] cmd_x,
  input  logic signed [CORDW-1:0] cmd_y,
  input  logic signed [VELW-1:0]  cmd_vx,
  input  logic signed [VELW-1:0]  cmd_vy,
  output logic signed [CORDW-1:0] obj_x,
  output logic signed [CORDW-1:0] obj_y,
  output logic                    frame_tick,
`ifdef BOUNCE_EVENT_EN
  output logic                    bounce_x,
  output logic                    bounce_y,
  output logic [15:0]             bounce_count,
`endif
  output dbg_t                    dbg
);

  localparam logic signed [CORDW-1:0] LIMIT_X = CORDW'(WIDTH - OBJ_W);
  localparam logic signed [CORDW-1:0] LIMIT_Y = CORDW'(HEIGHT - OBJ_H);

  state_e                  state;
  logic                    pending;
  logic                    run_q;
  logic                    frame_edge;
  logic signed [CORDW-1:0] wx, wy;
  logic signed [VELW-1:0]  vx, vy;

  logic signed [CORDW-1:0] sel_pos, sel_lim, next_pos, step_pos;
  logic signed [VELW-1:0]  sel_v, step_v;
`ifdef BOUNCE_EVENT_EN
  logic                    step_b;
  logic                    bx_q, by_q;
`endif

  rise_detect u_vsync_rise (
    .clk_pix   (clk_pix),
    .btn_rst_n (btn_rst_n),
    .sig       (vsync),
    .rise      (frame_edge)
  );

  // Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready.
  // cmd_ready is only offered in IDLE and is withdrawn when a frame edge arrives, so the frame wins.
  assign cmd_ready = run_q && (state == S_IDLE) && !frame_edge;

  // One shared step/bounce unit, switched between axes by the CALC state.
  always_comb begin
    sel_pos = wx;
    sel_v   = vx;
    sel_lim = LIMIT_X;
    if (state == S_CALC_Y) begin
      sel_pos = wy;
      sel_v   = vy;
      sel_lim = LIMIT_Y;
    end
    next_pos = sel_pos + {{(CORDW-VELW){sel_v[VELW-1]}}, sel_v};
    step_pos = next_pos;
    step_v   = sel_v;
`ifdef BOUNCE_EVENT_EN
    step_b   = 1'b0;
`endif
    if (next_pos < 0) begin
      step_pos = '0;
      step_v   = -sel_v;
`ifdef BOUNCE_EVENT_EN
      step_b   = 1'b1;
`endif
    end else if (next_pos > sel_lim) begin
      step_pos = sel_lim;
      step_v   = -sel_v;
`ifdef BOUNCE_EVENT_EN
      step_b   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_pix or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      state      <= S_IDLE;
      pending    <= 1'b0;
      run_q      <= 1'b0;
      wx         <= '0;
      wy         <= '0;
      vx         <= VELW'(RST_VX);
      vy         <= VELW'(RST_VY);
      obj_x      <= '0;
      obj_y      <= '0;
      frame_tick <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      frame_tick <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_edge) begin
            state <= S_CALC_X;
          end else if (cmd_valid && cmd_ready) begin
            wx      <= clamp_pos(cmd_x, LIMIT_X);
            wy      <= clamp_pos(cmd_y, LIMIT_Y);
            vx      <= sat_vel(cmd_vx);
            vy      <= sat_vel(cmd_vy);
            pending <= 1'b1;
          end
        end
        S_CALC_X: begin
          state <= S_CALC_Y;
          if (!pending) begin
            wx <= step_pos;
            vx <= step_v;
          end
        end
        S_CALC_Y: begin
          state <= S_PUBLISH;
          if (!pending) begin
            wy <= step_pos;
            vy <= step_v;
          end
        end
        S_PUBLISH: begin
          state      <= S_IDLE;
          obj_x      <= wx;
          obj_y      <= wy;
          frame_tick <= 1'b1;
          pending    <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BOUNCE_EVENT_EN
  // A freshly loaded command is published unstepped, so it can never report a bounce.
  always_ff @(posedge clk_pix or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      bx_q         <= 1'b0;
      by_q         <= 1'b0;
      bounce_x     <= 1'b0;
      bounce_y     <= 1'b0;
      bounce_count <= '0;
    end else begin
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      if (state == S_CALC_X)
        bx_q <= step_b && !pending;
      if (state == S_CALC_Y)
        by_q <= step_b && !pending;
      if (state == S_PUBLISH) begin
        bounce_x     <= bx_q;
        bounce_y     <= by_q;
        bounce_count <= bounce_count + 16'(bx_q) + 16'(by_q);
      end
    end
  end
`endif

  assign dbg = '{state: state, pending: pending, vx: vx, vy: vy};

endmodule
